// File: rtl/identify_queue.sv
// identify_queue: pairs prefix words with suffixes, classifies each instruction
// and buffers one record per instruction in a show-ahead FIFO.
module identify_queue #(
  parameter int DEPTH = 4,
  parameter int ALLOW_PREFIX = 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [0:31]      i_instr,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [0:31]      o_prefix,
  output logic [0:31]      o_suffix,
  output logic [2:0]       o_class,
  output logic [3:0]       o_subop,
  output logic [CNT_W-1:0] o_count,
  output logic             o_stall_fetch_arb
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  typedef enum logic {IDLE, PFX} state_t;
  state_t r_state, w_next;
  logic [0:31] r_pfx;
  logic [0:31] r_mp [DEPTH];
  logic [0:31] r_ms [DEPTH];
  logic [2:0] r_mc [DEPTH];
  logic [3:0] r_mo [DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [CNT_W-1:0] r_count;
  logic [5:0] w_op;
  logic [9:0] w_xo;
  logic [2:0] w_cls;
  logic [3:0] w_sub;
  logic w_acc, w_start, w_push, w_pop;
  assign w_op = i_instr[0:5];
  assign w_xo = i_instr[21:30];
  assign o_ready = ~i_rst & ~i_flush & (r_count < FULL);
  assign o_stall_fetch_arb = ~o_ready;
  assign o_valid = r_count != '0;
  assign o_count = r_count;
  assign w_acc = i_valid & o_ready;
  assign w_start = (r_state == IDLE) && (w_op == 6'd1) && (ALLOW_PREFIX != 0);
  assign w_push = w_acc & ~w_start;
  assign w_pop = o_valid & i_ready;
  assign o_prefix = o_valid ? r_mp[r_rd] : '0;
  assign o_suffix = o_valid ? r_ms[r_rd] : '0;
  assign o_class = o_valid ? r_mc[r_rd] : '0;
  assign o_subop = o_valid ? r_mo[r_rd] : '0;
  always_comb begin
    w_next = r_state;
    if (w_acc) w_next = w_start ? PFX : IDLE;
  end
  always_comb begin
    w_cls = 3'd0;
    w_sub = 4'd0;
    if (r_state == PFX) w_cls = (w_op == 6'd1) ? 3'd4 : 3'd3;
    else if (w_op == 6'd18) w_cls = 3'd1;
    else if (w_op == 6'd16) begin
      w_cls = 3'd1;
      w_sub = 4'd1;
    end else if (w_op == 6'd19) begin
      case (w_xo)
        10'd16:  begin w_cls = 3'd1; w_sub = 4'd2; end
        10'd528: begin w_cls = 3'd1; w_sub = 4'd3; end
        10'd560: begin w_cls = 3'd1; w_sub = 4'd4; end
        10'd257: begin w_cls = 3'd2; w_sub = 4'd0; end
        10'd225: begin w_cls = 3'd2; w_sub = 4'd1; end
        10'd449: begin w_cls = 3'd2; w_sub = 4'd2; end
        10'd193: begin w_cls = 3'd2; w_sub = 4'd3; end
        10'd33:  begin w_cls = 3'd2; w_sub = 4'd4; end
        10'd289: begin w_cls = 3'd2; w_sub = 4'd5; end
        10'd129: begin w_cls = 3'd2; w_sub = 4'd6; end
        10'd417: begin w_cls = 3'd2; w_sub = 4'd7; end
        10'd0:   begin w_cls = 3'd2; w_sub = 4'd8; end
        default: ;
      endcase
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_pfx <= '0;
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_mp[k] <= '0;
        r_ms[k] <= '0;
        r_mc[k] <= '0;
        r_mo[k] <= '0;
      end
    end else if (i_flush) begin
      r_state <= IDLE;
      r_pfx <= '0;
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc & w_start) r_pfx <= i_instr;
      if (w_push) begin
        r_mp[r_wr] <= (r_state == PFX) ? r_pfx : '0;
        r_ms[r_wr] <= i_instr;
        r_mc[r_wr] <= w_cls;
        r_mo[r_wr] <= w_sub;
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end
endmodule

// File: tb/tb_identify_queue.sv
// tb_identify_queue: directed checks of classification, prefix pairing, FIFO and flush.
module tb_identify_queue;
  logic clk = 1'b0;
  logic i_rst = 1'b1, i_flush = 1'b0, i_valid = 1'b0, i_ready = 1'b0;
  logic [0:31] i_instr = '0;
  logic o_ready, o_valid, o_stall_fetch_arb;
  logic [0:31] o_prefix, o_suffix;
  logic [2:0] o_class;
  logic [3:0] o_subop;
  logic [2:0] o_count;
  int n_tests = 0, n_fail = 0;
  logic [31:0] cw [8] = '{32'h4E800420, 32'h4C000460, 32'h4C000000, 32'h4C000182,
                          32'h4C000342, 32'h40000000, 32'h38600001, 32'h4C00012C};
  logic [2:0] cc [8] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd1, 3'd0, 3'd0};
  logic [3:0] cs [8] = '{4'd3, 4'd4, 4'd8, 4'd3, 4'd7, 4'd1, 4'd0, 4'd0};

  identify_queue dut (
    .i_clk(clk), .i_rst(i_rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_instr(i_instr), .o_valid(o_valid), .i_ready(i_ready), .o_prefix(o_prefix),
    .o_suffix(o_suffix), .o_class(o_class), .o_subop(o_subop), .o_count(o_count),
    .o_stall_fetch_arb(o_stall_fetch_arb)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    i_valid = 1'b1;
    i_instr = w;
    step();
    i_valid = 1'b0;
  endtask

  task automatic drain();
    i_ready = 1'b1;
    repeat (5) step();
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    #1;
    n_tests++;
    if (o_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b exp 0", o_ready); end
    step();
    n_tests++;
    if ({o_valid, o_count, o_class, o_subop, o_prefix, o_suffix} !== '0) begin
      n_fail++; $display("FAIL reset_state: got v=%b c=%0d cls=%0d", o_valid, o_count, o_class);
    end
    i_rst = 1'b0;
    #1;
    n_tests++;
    if ({o_ready, o_stall_fetch_arb} !== 2'b10) begin
      n_fail++; $display("FAIL reset_release: got ready=%b stall=%b exp 1/0", o_ready, o_stall_fetch_arb);
    end
  endtask

  task automatic test_branch();
    i_ready = 1'b1;
    push(32'h48000000);
    n_tests++;
    if ({o_valid, o_class, o_subop, o_prefix, o_suffix, o_count} !== {1'b1, 3'd1, 4'd0, 32'h0, 32'h48000000, 3'd1}) begin
      n_fail++; $display("FAIL branch_i: got v=%b cls=%0d sub=%0d sfx=%h cnt=%0d", o_valid, o_class, o_subop, o_suffix, o_count);
    end
    step();
    n_tests++;
    if ({o_valid, o_count, o_class} !== 7'd0) begin
      n_fail++; $display("FAIL branch_pop: got v=%b cnt=%0d cls=%0d exp 0", o_valid, o_count, o_class);
    end
    step();
    n_tests++;
    if (o_count !== 3'd0) begin n_fail++; $display("FAIL pop_empty: got %0d exp 0", o_count); end
    i_ready = 1'b0;
  endtask

  task automatic test_order();
    push(32'h4C000202);
    push(32'h4E800020);
    n_tests++;
    if ({o_count, o_valid, o_class, o_subop, o_prefix, o_suffix} !== {3'd2, 1'b1, 3'd2, 4'd0, 32'h0, 32'h4C000202}) begin
      n_fail++; $display("FAIL crand_head: got cnt=%0d cls=%0d sub=%0d sfx=%h", o_count, o_class, o_subop, o_suffix);
    end
    i_ready = 1'b1;
    step();
    n_tests++;
    if ({o_count, o_valid, o_class, o_subop, o_suffix} !== {3'd1, 1'b1, 3'd1, 4'd2, 32'h4E800020}) begin
      n_fail++; $display("FAIL bclr_head: got cnt=%0d cls=%0d sub=%0d sfx=%h", o_count, o_class, o_subop, o_suffix);
    end
    drain();
  endtask

  task automatic test_classify();
    for (int i = 0; i < 8; i++) begin
      push(cw[i]);
      n_tests++;
      if ({o_valid, o_class, o_subop, o_suffix} !== {1'b1, cc[i], cs[i], cw[i]}) begin
        n_fail++; $display("FAIL classify_%0d: got cls=%0d sub=%0d sfx=%h exp %0d/%0d", i, o_class, o_subop, o_suffix, cc[i], cs[i]);
      end
      drain();
    end
  endtask

  task automatic test_prefix();
    push(32'h04000000);
    n_tests++;
    if ({o_valid, o_count} !== 4'd0) begin
      n_fail++; $display("FAIL prefix_alone: got v=%b cnt=%0d exp 0", o_valid, o_count);
    end
    push(32'h38600001);
    n_tests++;
    if ({o_count, o_class, o_subop, o_prefix, o_suffix} !== {3'd1, 3'd3, 4'd0, 32'h04000000, 32'h38600001}) begin
      n_fail++; $display("FAIL prefix_pair: got cnt=%0d cls=%0d pfx=%h sfx=%h", o_count, o_class, o_prefix, o_suffix);
    end
    drain();
  endtask

  task automatic test_pfx_err();
    push(32'h04000000);
    push(32'h04000010);
    push(32'h48000000);
    n_tests++;
    if ({o_count, o_class, o_subop, o_prefix, o_suffix} !== {3'd2, 3'd4, 4'd0, 32'h04000000, 32'h04000010}) begin
      n_fail++; $display("FAIL pfx_err: got cnt=%0d cls=%0d pfx=%h sfx=%h", o_count, o_class, o_prefix, o_suffix);
    end
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    n_tests++;
    if ({o_count, o_class, o_subop, o_prefix, o_suffix} !== {3'd1, 3'd1, 4'd0, 32'h0, 32'h48000000}) begin
      n_fail++; $display("FAIL after_err: got cnt=%0d cls=%0d pfx=%h sfx=%h", o_count, o_class, o_prefix, o_suffix);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] q[$];
    int n = 0;
    logic rdy, pop;
    i_valid = 1'b1;
    i_instr = 32'h38600100;
    for (int c = 0; c < 16; c++) begin
      if (c == 6) i_ready = 1'b1;
      #1;
      rdy = q.size() < 4;
      pop = q.size() > 0 && i_ready;
      n_tests++;
      if ({o_ready, o_stall_fetch_arb, o_count, o_valid} !== {rdy, ~rdy, 3'(q.size()), q.size() > 0}) begin
        n_fail++; $display("FAIL b2b_ctl_%0d: got ready=%b cnt=%0d v=%b exp ready=%b cnt=%0d", c, o_ready, o_count, o_valid, rdy, q.size());
      end
      if (q.size() > 0) begin
        n_tests++;
        if (o_suffix !== q[0]) begin n_fail++; $display("FAIL b2b_head_%0d: got %h exp %h", c, o_suffix, q[0]); end
      end
      step();
      if (pop) void'(q.pop_front());
      if (rdy) begin
        q.push_back(32'h38600100 + n);
        n++;
        i_instr = 32'h38600100 + n;
      end
    end
    i_valid = 1'b0;
    drain();
  endtask

  task automatic test_flush();
    push(32'h38600002);
    push(32'h38600003);
    push(32'h04000000);
    i_flush = 1'b1;
    i_valid = 1'b1;
    i_instr = 32'h48000000;
    #1;
    n_tests++;
    if ({o_count, o_ready} !== {3'd2, 1'b0}) begin
      n_fail++; $display("FAIL flush_pre: got cnt=%0d ready=%b exp 2/0", o_count, o_ready);
    end
    step();
    i_flush = 1'b0;
    i_valid = 1'b0;
    n_tests++;
    if ({o_count, o_valid, o_suffix} !== '0) begin
      n_fail++; $display("FAIL flush_clear: got cnt=%0d v=%b sfx=%h exp 0", o_count, o_valid, o_suffix);
    end
    push(32'h38600001);
    n_tests++;
    if ({o_count, o_class, o_subop, o_prefix, o_suffix} !== {3'd1, 3'd0, 4'd0, 32'h0, 32'h38600001}) begin
      n_fail++; $display("FAIL flush_next: got cnt=%0d cls=%0d pfx=%h sfx=%h", o_count, o_class, o_prefix, o_suffix);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    push(32'h48000000);
    push(32'h04000000);
    i_rst = 1'b1;
    i_flush = 1'b1;
    step();
    i_rst = 1'b0;
    i_flush = 1'b0;
    n_tests++;
    if ({o_count, o_valid} !== 4'd0) begin
      n_fail++; $display("FAIL rst_mid: got cnt=%0d v=%b exp 0", o_count, o_valid);
    end
    push(32'h38600001);
    n_tests++;
    if ({o_count, o_class, o_prefix, o_suffix} !== {3'd1, 3'd0, 32'h0, 32'h38600001}) begin
      n_fail++; $display("FAIL rst_mid_next: got cnt=%0d cls=%0d pfx=%h sfx=%h", o_count, o_class, o_prefix, o_suffix);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_branch();
    test_order();
    test_classify();
    test_prefix();
    test_pfx_err();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
